// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle between the cache, the refill controller and backing memory.
// The controller attaches through the slave modport; the cache/memory side
// uses the master modport.
interface cache_refill_ctrl_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    // Miss request from the cache
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              busy;

    // Fill stream and write completion back to the cache
    logic              fill_valid;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              fill_last;
    logic              wr_done;

    // Backing-memory bus
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, busy, fill_valid, fill_idx, fill_data, fill_last,
               wr_done, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, busy, fill_valid, fill_idx, fill_data, fill_last,
               wr_done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss-service controller: critical-word-first line refill on read
// misses, single-word no-allocate write on write misses.
module cache_refill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    cache_refill_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]        state_reg;
    logic [ADDR_W-3:0] addr_reg;       // word address of the request
    logic [DATA_W-1:0] wdata_reg;
    logic [IDX_W-1:0]  cur_idx_reg;    // word index being fetched
    logic [CNT_W-1:0]  remaining_reg;  // words still to be acked
    logic              fill_valid_reg;
    logic [IDX_W-1:0]  fill_idx_reg;
    logic [DATA_W-1:0] fill_data_reg;
    logic              fill_last_reg;
    logic              wr_done_reg;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              unused_addr_bits;

    // Byte-lane bits of the request address carry no meaning here
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // Line base keeps the tag/set bits; only the index field walks, so the
    // burst wraps inside the line and never carries into the next one
    assign rd_addr = {addr_reg[ADDR_W-3:IDX_W], cur_idx_reg, 2'b00};
    assign wr_addr = {addr_reg, 2'b00};

    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.mem_req    = (state_reg != ST_IDLE);
    assign bus.mem_we     = (state_reg == ST_WR);
    assign bus.fill_valid = fill_valid_reg;
    assign bus.fill_idx   = fill_idx_reg;
    assign bus.fill_data  = fill_data_reg;
    assign bus.fill_last  = fill_last_reg;
    assign bus.wr_done    = wr_done_reg;

    // Memory address/data derived from held state, so they stay put across wait states
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_reg)
            ST_RD: bus.mem_addr = rd_addr;
            ST_WR: begin
                bus.mem_addr  = wr_addr;
                bus.mem_wdata = wdata_reg;
            end
            default: ;
        endcase
    end

    // Request acceptance, burst sequencing and single-cycle completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cur_idx_reg    <= '0;
            remaining_reg  <= '0;
            fill_valid_reg <= 1'b0;
            fill_idx_reg   <= '0;
            fill_data_reg  <= '0;
            fill_last_reg  <= 1'b0;
            wr_done_reg    <= 1'b0;
        end else begin
            fill_valid_reg <= 1'b0;
            fill_last_reg  <= 1'b0;
            wr_done_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_reg      <= bus.req_addr[ADDR_W-1:2];
                        wdata_reg     <= bus.req_wdata;
                        cur_idx_reg   <= bus.req_addr[IDX_W+1:2];
                        remaining_reg <= CNT_W'(WORDS_PER_LINE);
                        state_reg     <= bus.req_write ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (bus.mem_ack) begin
                        fill_valid_reg <= 1'b1;
                        fill_idx_reg   <= cur_idx_reg;
                        fill_data_reg  <= bus.mem_rdata;
                        cur_idx_reg    <= cur_idx_reg + 1'b1;
                        remaining_reg  <= remaining_reg - 1'b1;
                        if (remaining_reg == CNT_W'(1)) begin
                            fill_last_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.mem_ack) begin
                        wr_done_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus
// randomized reads/writes against a line-order reference model.
module tb_cache_refill_ctrl;
    localparam int W  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] RD_XOR = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    cache_refill_ctrl_if #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_refill_ctrl #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory returns a data pattern derived from the address it is given
    assign bus.mem_rdata = bus.mem_addr ^ RD_XOR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: k-th word of a critical-word-first burst for byte address a
    function automatic int unsigned exp_idx(input logic [31:0] a, input int k);
        return ((a / 4) + k) % W;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
        logic [31:0] base;
        base = a - (a % (W * 4));
        return base + exp_idx(a, k) * 4;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".req_ready"},  32'(bus.req_ready), 1);
        chk({tag, ".busy"},       32'(bus.busy), 0);
        chk({tag, ".fill_valid"}, 32'(bus.fill_valid), 0);
        chk({tag, ".fill_last"},  32'(bus.fill_last), 0);
        chk({tag, ".wr_done"},    32'(bus.wr_done), 0);
        chk({tag, ".mem_req"},    32'(bus.mem_req), 0);
        chk({tag, ".mem_we"},     32'(bus.mem_we), 0);
        chk({tag, ".mem_addr"},   bus.mem_addr, 0);
        chk({tag, ".mem_wdata"},  bus.mem_wdata, 0);
        chk({tag, ".fill_idx"},   32'(bus.fill_idx), 0);
        chk({tag, ".fill_data"},  bus.fill_data, 0);
    endtask

    // mode: 0 ack every cycle, 1 ack toggles 1,0,1,0..., 2 random acks.
    // hold_next: present the follow-up write while the fill runs.
    // abort_at: assert reset once that many fill words have been seen (<=0 = never).
    task automatic run_read(input logic [31:0] a, input int mode, input bit hold_next, input int abort_at);
        int  k = 0;
        bit  prev_ack = 1'b0;
        bit  done = 1'b0;
        bit  ack;
        bit  exp_ready;
        @(negedge clk);
        chk("rd.ready_before", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = $urandom;
        @(posedge clk);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (hold_next) begin
                    bus.req_write = 1'b1;
                    bus.req_addr  = 32'hFFFF_FFFC;
                    bus.req_wdata = 32'h5555_5555;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            exp_ready = prev_ack && (k == W);
            if (prev_ack) begin
                chk("rd.fill_valid", 32'(bus.fill_valid), 1);
                chk("rd.fill_idx",   32'(bus.fill_idx), exp_idx(a, k - 1));
                chk("rd.fill_data",  bus.fill_data, exp_addr(a, k - 1) ^ RD_XOR);
                chk("rd.fill_last",  32'(bus.fill_last), 32'(k == W));
            end else begin
                chk("rd.fill_gap", 32'(bus.fill_valid), 0);
            end
            chk("rd.req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rd.busy",      32'(bus.busy), 32'(!exp_ready));
            chk("rd.wr_done",   32'(bus.wr_done), 0);
            if (abort_at > 0 && prev_ack && k == abort_at) begin
                reset = 1'b1;
                bus.mem_ack = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_idle("abort");
                reset = 1'b0;
                done = 1'b1;
            end else if (k < W) begin
                chk("rd.mem_req",  32'(bus.mem_req), 1);
                chk("rd.mem_we",   32'(bus.mem_we), 0);
                chk("rd.mem_addr", bus.mem_addr, exp_addr(a, k));
                case (mode)
                    0:       ack = 1'b1;
                    1:       ack = (cyc % 2 == 0);
                    default: ack = ($urandom_range(0, 2) != 0);
                endcase
                bus.mem_ack = ack;
                prev_ack = ack;
                if (ack) k++;
            end else begin
                chk("rd.mem_req_end", 32'(bus.mem_req), 0);
                bus.mem_ack = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) chk("rd.timeout", 0, 1);
        $display("read  addr=%h mode=%0d words_acked=%0d abort_at=%0d", a, mode, k, abort_at);
    endtask

    // pre: request is already on the bus and will be accepted at the next edge
    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int waits, input bit pre);
        if (!pre) begin
            @(negedge clk);
            chk("wr.ready_before", 32'(bus.req_ready), 1);
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = a;
            bus.req_wdata = d;
        end
        @(posedge clk);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            if (i == 0) bus.req_valid = 1'b0;
            chk("wr.mem_req",    32'(bus.mem_req), 1);
            chk("wr.mem_we",     32'(bus.mem_we), 1);
            chk("wr.mem_addr",   bus.mem_addr, a - (a % 4));
            chk("wr.mem_wdata",  bus.mem_wdata, d);
            chk("wr.wr_done",    32'(bus.wr_done), 0);
            chk("wr.fill_valid", 32'(bus.fill_valid), 0);
            chk("wr.busy",       32'(bus.busy), 1);
            bus.mem_ack = (i == waits);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("wr.done_pulse", 32'(bus.wr_done), 1);
        chk("wr.ready",      32'(bus.req_ready), 1);
        chk("wr.mem_req_end", 32'(bus.mem_req), 0);
        chk("wr.no_fill",    32'(bus.fill_valid), 0);
        @(negedge clk);
        chk("wr.done_single", 32'(bus.wr_done), 0);
        $display("write addr=%h data=%h waits=%0d", a, d, waits);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        $display("reset released");

        // Stray acks while idle must be ignored
        bus.mem_ack = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle_ack");
        end
        bus.mem_ack = 1'b0;
        $display("idle ack hold done");

        run_read(32'hFFFF_FFFC, 0, 1'b0, 0);
        run_write(32'h0000_0000, 32'h5678_9001, 3, 1'b0);
        run_read(32'h0000_0004, 1, 1'b0, 0);
        run_read(32'h1000_0008, 0, 1'b1, 0);
        run_write(32'hFFFF_FFFC, 32'h5555_5555, 1, 1'b1);
        run_read(32'h2000_0000, 0, 1'b0, 2);
        run_read(32'h2000_0000, 2, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                run_write($urandom, $urandom, $urandom_range(0, 3), 1'b0);
            else
                run_read($urandom, 2, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
